jam_cost_sequencer: RTL and testbench
=====================================

Name: jam_cost_sequencer

Overview:
- Upstream feeder and run controller for the JAM job-assignment engine (8 workers x 8 jobs).
- Loads a 64-entry, 7-bit cost table from a valid/ready stream in row-major order: index = 8*worker + job.
- While loading, holds JAM in reset; then releases it and answers its W/J cost lookups with JAM's one-cycle address-to-data timing.
- Captures MinCost/MatchCount and the run's cycle count when JAM asserts Valid, then re-arms for the next table.

Parameters:
- COST_W, 7, cost word width.
- CYC_W, 24, width of the run-cycle counter and RES_CYCLES.
- TIMEOUT, 10000000, RUN-state cycles before a run is aborted as timed out; must be < 2^CYC_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  cost stream word valid.
- IN_READY  out  1  block accepts a stream word.
- IN_DATA  in  COST_W  cost word; the n-th accepted word is table[n], n = 0..63.
- JAM_RST  out  1  active-high reset driven to JAM.
- W  in  3  worker index from JAM.
- J  in  3  job index from JAM.
- Cost  out  COST_W  table[8*W_q+J_q].
- JAM_VALID  in  1  JAM Valid.
- MinCost  in  10  JAM minimum cost.
- MatchCount  in  4  JAM match count.
- RES_VALID  out  1  one-cycle pulse: result registers updated.
- RES_MIN_COST  out  10  captured MinCost.
- RES_MATCH_COUNT  out  4  captured MatchCount.
- RES_CYCLES  out  CYC_W  RUN cycles up to and including the JAM_VALID cycle.
- RES_TIMEOUT  out  1  last run ended by timeout.

Behaviour:
- Reset (RST_N=0, asynchronous): state=LOAD, load count=0, all table entries=0, W_q=J_q=0, run counter=0.
- Reset output values: IN_READY=0, JAM_RST=1, Cost=0, RES_VALID=0, RES_MIN_COST=0, RES_MATCH_COUNT=0, RES_CYCLES=0, RES_TIMEOUT=0.
- IN_READY is 0 while RST_N=0 and rises on the first clock edge after RST_N deasserts.
- Reset mid-operation aborts any load or run and returns to the reset values above; the next load starts again at index 0.
- Lookup path, active in every state:
  - W_q<=W and J_q<=J on each rising edge.
  - Cost is combinational from table[8*W_q+J_q].
  - Cost for an address presented in cycle t is therefore valid throughout cycle t+1.
- LOAD state:
  - IN_READY=1, JAM_RST=1.
  - On IN_VALID&&IN_READY: table[count]<=IN_DATA, count++.
  - IN_VALID low stalls the load with no side effect.
  - On the 64th accept (count=63), next state=RUN and count wraps to 0. IN_READY=0 and JAM_RST=0 from the following cycle.
  - JAM_VALID is ignored in LOAD.
- RUN state:
  - IN_READY=0; stream words are not accepted and the table is frozen. JAM_RST=0.
  - Run counter: cleared on entry, increments each RUN cycle, saturates at all-ones.
  - On JAM_VALID=1:
    - RES_MIN_COST<=MinCost, RES_MATCH_COUNT<=MatchCount.
    - RES_CYCLES<=counter+1 (saturating), RES_TIMEOUT<=0.
    - RES_VALID=1 for exactly the next cycle.
    - state<=LOAD, so JAM_RST=1 and IN_READY=1 in that same next cycle.
  - Timeout: if counter+1 reaches TIMEOUT with JAM_VALID=0, then RES_TIMEOUT<=1, RES_MIN_COST<=0, RES_MATCH_COUNT<=0, RES_CYCLES<=TIMEOUT, RES_VALID pulses, and state<=LOAD.
  - If JAM_VALID and the timeout condition occur in the same cycle, JAM_VALID wins: normal capture, RES_TIMEOUT=0.
- Result registers hold their values until the next capture.
- Only one RES_VALID pulse is produced per run.
- The table is overwritten on each reload; entries not yet rewritten keep the previous run's values.

Test Plan:
- Reset, then stream table[i]=i (0..63) with IN_VALID held high -> IN_READY high for exactly 64 cycles; JAM_RST falls the cycle after the 64th accept; W=5,J=3 presented in cycle t gives Cost=43 in cycle t+1.
- Same load with IN_VALID toggling 1/0 -> 64 accepts take 127 cycles; table contents are identical; no write occurs on stalled cycles.
- In RUN, drive JAM_VALID=1 with MinCost=372, MatchCount=6 on the 100th RUN cycle -> RES_VALID single pulse, RES_MIN_COST=372, RES_MATCH_COUNT=6, RES_CYCLES=100, RES_TIMEOUT=0, JAM_RST=1, IN_READY=1.
- TIMEOUT=50, never assert JAM_VALID -> RES_VALID pulse after 50 RUN cycles with RES_TIMEOUT=1, RES_CYCLES=50, RES_MIN_COST=0; block back in LOAD.
- Pull RST_N low after 30 accepted words -> all outputs return to reset values immediately; a fresh load takes 64 accepts; Cost for W=0,J=0 equals the first word of the new stream.
- JAM_VALID=1 during LOAD, and JAM_VALID coincident with the timeout cycle (TIMEOUT=50) -> no capture during LOAD; on the coincident cycle, a normal capture with RES_TIMEOUT=0 and RES_CYCLES=50.

Source files
------------

// File: rtl/jam_cost_sequencer.sv
// Cost-table feeder and run controller for the 8x8 JAM assignment engine: stream load, 1-cycle lookup, result capture.
// Lookup latency 1 cycle; IN_READY is registered and drops the cycle after the 64th accepted word.
module jam_cost_sequencer #(
  parameter int COST_W  = 7,
  parameter int CYC_W   = 24,
  parameter int TIMEOUT = 10000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [COST_W-1:0] IN_DATA,
  output logic              JAM_RST,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              JAM_VALID,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  output logic              RES_VALID,
  output logic [9:0]        RES_MIN_COST,
  output logic [3:0]        RES_MATCH_COUNT,
  output logic [CYC_W-1:0]  RES_CYCLES,
  output logic              RES_TIMEOUT
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

  state_t             state;
  logic [5:0]         load_cnt;
  logic [COST_W-1:0]  cost_tbl [64];
  logic [2:0]         w_q;
  logic [2:0]         j_q;
  logic [CYC_W-1:0]   run_cnt;
  logic [CYC_W-1:0]   run_cnt_inc;
  logic               accept;
  logic               timeout_hit;

  assign run_cnt_inc = (&run_cnt) ? run_cnt : run_cnt + CYC_W'(1);
  assign accept      = (state == LOAD) && IN_VALID && IN_READY;
  assign timeout_hit = (state == RUN) && (run_cnt_inc == TIMEOUT_C);
  assign Cost        = cost_tbl[{w_q, j_q}];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 64; i++) cost_tbl[i] <= '0;
    end else if (accept) begin
      cost_tbl[load_cnt] <= IN_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= LOAD;
      load_cnt        <= '0;
      w_q             <= '0;
      j_q             <= '0;
      run_cnt         <= '0;
      IN_READY        <= 1'b0;
      JAM_RST         <= 1'b1;
      RES_VALID       <= 1'b0;
      RES_MIN_COST    <= '0;
      RES_MATCH_COUNT <= '0;
      RES_CYCLES      <= '0;
      RES_TIMEOUT     <= 1'b0;
    end else begin
      w_q       <= W;
      j_q       <= J;
      RES_VALID <= 1'b0;
      case (state)
        LOAD: begin
          IN_READY <= 1'b1;
          JAM_RST  <= 1'b1;
          if (accept) begin
            load_cnt <= load_cnt + 6'd1;
            if (load_cnt == 6'd63) begin
              state    <= RUN;
              run_cnt  <= '0;
              IN_READY <= 1'b0;
              JAM_RST  <= 1'b0;
            end
          end
        end
        RUN: begin
          IN_READY <= 1'b0;
          JAM_RST  <= 1'b0;
          run_cnt  <= run_cnt_inc;
          // A real result beats a timeout landing in the same cycle.
          if (JAM_VALID) begin
            RES_MIN_COST    <= MinCost;
            RES_MATCH_COUNT <= MatchCount;
            RES_CYCLES      <= run_cnt_inc;
            RES_TIMEOUT     <= 1'b0;
            RES_VALID       <= 1'b1;
            state           <= LOAD;
            IN_READY        <= 1'b1;
            JAM_RST         <= 1'b1;
          end else if (timeout_hit) begin
            RES_MIN_COST    <= '0;
            RES_MATCH_COUNT <= '0;
            RES_CYCLES      <= TIMEOUT_C;
            RES_TIMEOUT     <= 1'b1;
            RES_VALID       <= 1'b1;
            state           <= LOAD;
            IN_READY        <= 1'b1;
            JAM_RST         <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_sequencer.sv
// Directed bench: instance a uses the default timeout, instance b a 50-cycle timeout; both share stimulus.
module tb_jam_cost_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [6:0] IN_DATA = '0;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic       JAM_VALID = 1'b0;
  logic [9:0] MinCost = '0;
  logic [3:0] MatchCount = '0;

  logic        a_in_ready, a_jam_rst, a_res_valid, a_res_timeout;
  logic [6:0]  a_cost;
  logic [9:0]  a_res_min_cost;
  logic [3:0]  a_res_match_count;
  logic [23:0] a_res_cycles;
  logic        b_in_ready, b_jam_rst, b_res_valid, b_res_timeout;
  logic [6:0]  b_cost;
  logic [9:0]  b_res_min_cost;
  logic [3:0]  b_res_match_count;
  logic [23:0] b_res_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  always #5 CLK = ~CLK;

  jam_cost_sequencer u_a (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(a_in_ready), .IN_DATA(IN_DATA),
    .JAM_RST(a_jam_rst), .W(W), .J(J), .Cost(a_cost), .JAM_VALID(JAM_VALID),
    .MinCost(MinCost), .MatchCount(MatchCount), .RES_VALID(a_res_valid),
    .RES_MIN_COST(a_res_min_cost), .RES_MATCH_COUNT(a_res_match_count),
    .RES_CYCLES(a_res_cycles), .RES_TIMEOUT(a_res_timeout)
  );

  jam_cost_sequencer #(.TIMEOUT(50)) u_b (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(b_in_ready), .IN_DATA(IN_DATA),
    .JAM_RST(b_jam_rst), .W(W), .J(J), .Cost(b_cost), .JAM_VALID(JAM_VALID),
    .MinCost(MinCost), .MatchCount(MatchCount), .RES_VALID(b_res_valid),
    .RES_MIN_COST(b_res_min_cost), .RES_MATCH_COUNT(b_res_match_count),
    .RES_CYCLES(b_res_cycles), .RES_TIMEOUT(b_res_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input bit sel_b);
    if (sel_b) begin
      chk("rst_in_ready", b_in_ready, 0);      chk("rst_jam_rst", b_jam_rst, 1);
      chk("rst_cost", b_cost, 0);              chk("rst_res_valid", b_res_valid, 0);
      chk("rst_min_cost", b_res_min_cost, 0);  chk("rst_match", b_res_match_count, 0);
      chk("rst_cycles", b_res_cycles, 0);      chk("rst_timeout", b_res_timeout, 0);
    end else begin
      chk("rst_in_ready", a_in_ready, 0);      chk("rst_jam_rst", a_jam_rst, 1);
      chk("rst_cost", a_cost, 0);              chk("rst_res_valid", a_res_valid, 0);
      chk("rst_min_cost", a_res_min_cost, 0);  chk("rst_match", a_res_match_count, 0);
      chk("rst_cycles", a_res_cycles, 0);      chk("rst_timeout", a_res_timeout, 0);
    end
  endtask

  // Caller has RST_N low; releases it just after an edge and checks IN_READY rises one edge later.
  task automatic release_reset();
    step();
    RST_N = 1'b1;
    chk("ready_at_release", a_in_ready, 0);
    step();
    chk("ready_after_release", a_in_ready, 1);
  endtask

  // Word n carries (base+n) mod 128; stalled cycles drive 7F so a stray write is visible.
  task automatic load_words(input bit toggle, input bit sel_b, input int base, input int nwords,
                            output int rdy_cyc, output int cyc);
    int n;
    logic rdy;
    n = 0;
    rdy_cyc = 0;
    cyc = 0;
    while (n < nwords && cyc < 400) begin
      IN_VALID = !toggle || (cyc % 2 == 0);
      IN_DATA  = IN_VALID ? 7'((base + n) % 128) : 7'h7F;
      rdy = sel_b ? b_in_ready : a_in_ready;
      if (rdy) rdy_cyc++;
      if (IN_VALID && rdy) n++;
      if (a_res_valid || b_res_valid) pulses++;
      step();
      cyc++;
    end
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    chk("load_done", n, nwords);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cyc, cyc;
    logic [5:0] adr;

    // Reset values, then a straight load of table[i]=i.
    step(); step();
    chk_reset_vals(0);
    chk_reset_vals(1);
    release_reset();
    load_words(0, 0, 0, 64, rdy_cyc, cyc);
    chk("t1_ready_cycles", rdy_cyc, 64);
    chk("t1_run_ready", a_in_ready, 0);
    chk("t1_run_jam_rst", a_jam_rst, 0);
    chk("t1_cost_00", a_cost, 0);
    W = 3'd5; J = 3'd3;
    step();
    chk("t1_cost_53", a_cost, 43);
    W = 3'd0; J = 3'd0;
    step();
    for (int r = 3; r < 100; r++) step();

    // JAM reports on RUN cycle 100.
    chk("t3_no_early_valid", a_res_valid, 0);
    JAM_VALID = 1'b1; MinCost = 10'd372; MatchCount = 4'd6;
    step();
    JAM_VALID = 1'b0; MinCost = '0; MatchCount = '0;
    chk("t3_res_valid", a_res_valid, 1);
    chk("t3_min_cost", a_res_min_cost, 372);
    chk("t3_match", a_res_match_count, 6);
    chk("t3_cycles", a_res_cycles, 100);
    chk("t3_timeout", a_res_timeout, 0);
    chk("t3_jam_rst", a_jam_rst, 1);
    chk("t3_ready", a_in_ready, 1);
    step();
    chk("t3_pulse_end", a_res_valid, 0);
    chk("t3_min_hold", a_res_min_cost, 372);

    // Stalling load: 64 accepts over 127 cycles, table identical.
    load_words(1, 0, 0, 64, rdy_cyc, cyc);
    chk("t2_cycles", cyc, 127);
    chk("t2_ready_cycles", rdy_cyc, 127);
    chk("t2_run_ready", a_in_ready, 0);
    for (int k = 0; k <= 64; k++) begin
      if (k > 0) chk("t2_table", a_cost, k - 1);
      if (k < 64) begin
        adr = 6'(k);
        W = adr[5:3];
        J = adr[2:0];
      end
      step();
    end
    W = 3'd0; J = 3'd0;

    // JAM_VALID held through LOAD is ignored; then JAM_VALID on the timeout cycle wins.
    RST_N = 1'b0;
    step();
    release_reset();
    pulses = 0;
    JAM_VALID = 1'b1; MinCost = 10'd999; MatchCount = 4'd9;
    load_words(0, 1, 20, 64, rdy_cyc, cyc);
    JAM_VALID = 1'b0; MinCost = '0; MatchCount = '0;
    chk("t6_no_load_pulse", pulses, 0);
    chk("t6_no_load_capture", b_res_min_cost, 0);
    chk("t6_in_run", b_jam_rst, 0);
    for (int r = 1; r < 50; r++) step();
    JAM_VALID = 1'b1; MinCost = 10'd200; MatchCount = 4'd3;
    step();
    JAM_VALID = 1'b0; MinCost = '0; MatchCount = '0;
    chk("t6_res_valid", b_res_valid, 1);
    chk("t6_timeout", b_res_timeout, 0);
    chk("t6_cycles", b_res_cycles, 50);
    chk("t6_min_cost", b_res_min_cost, 200);
    chk("t6_match", b_res_match_count, 3);

    // Timeout with no JAM_VALID.
    load_words(0, 1, 0, 64, rdy_cyc, cyc);
    pulses = 0;
    for (int r = 1; r < 50; r++) begin
      if (b_res_valid) pulses++;
      step();
    end
    chk("t4_no_early_pulse", pulses, 0);
    chk("t4_cycle50_valid", b_res_valid, 0);
    step();
    chk("t4_res_valid", b_res_valid, 1);
    chk("t4_timeout", b_res_timeout, 1);
    chk("t4_cycles", b_res_cycles, 50);
    chk("t4_min_cost", b_res_min_cost, 0);
    chk("t4_match", b_res_match_count, 0);
    chk("t4_ready", b_in_ready, 1);
    chk("t4_jam_rst", b_jam_rst, 1);
    step();
    chk("t4_pulse_end", b_res_valid, 0);

    // Reset in the middle of a load, then a fresh full load.
    load_words(0, 1, 50, 30, rdy_cyc, cyc);
    chk("t5_still_loading", b_in_ready, 1);
    RST_N = 1'b0;
    #1;
    chk_reset_vals(1);
    release_reset();
    load_words(0, 1, 9, 64, rdy_cyc, cyc);
    chk("t5_ready_cycles", rdy_cyc, 64);
    chk("t5_jam_rst", b_jam_rst, 0);
    chk("t5_cost_first", b_cost, 9);
    W = 3'd3; J = 3'd5;
    step();
    chk("t5_cost_29", b_cost, 38);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
